// File: rtl/change_disp_pkg.sv
// Shared types and constants for the change dispenser: FSM states, hopper coin
// bus encoding and the value of each coin in 5-unit steps.
package change_disp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_ERR
  } disp_state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b10;
  localparam logic [1:0] COIN_10   = 2'b11;

  localparam int unsigned UNITS_5  = 1;
  localparam int unsigned UNITS_10 = 2;

endpackage

// File: rtl/change_dispenser_timer.sv
// disp_timer: loadable down-counter shared by the inter-coin gap and the ack timeout.
// expire is high while the count sits at zero.
module disp_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Refund coin dispenser: greedy 10-unit coins then one 5-unit coin, each held until hopper ack.
// Optional ack timeout with retries enabled by defining COIN_DISP_TIMEOUT_EN.
module change_dispenser
  import change_disp_pkg::*;
#(
  parameter int unsigned AMT_W       = 4,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic [1:0]       coin_out,
  input  logic             coin_ack,
  output logic [AMT_W-1:0] remaining,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic             err_clr
);

`ifdef COIN_DISP_TIMEOUT_EN
  localparam int unsigned TMR_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
`else
  localparam int unsigned TMR_MAX = GAP_CYCLES;
`endif
  localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);
  // Timer expires on its load value + 1'th cycle, so load N-1 for an N-cycle window.
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
`ifdef COIN_DISP_TIMEOUT_EN
  localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);
`else
  localparam logic [TMR_W-1:0] ACK_LOAD = GAP_LOAD;
`endif

  disp_state_t      state, state_n;
  logic [1:0]       coin_n;
  logic [AMT_W-1:0] rem_n;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expire;

  function automatic logic [1:0] pick_coin(input logic [AMT_W-1:0] amt);
    return (amt >= AMT_W'(UNITS_10)) ? COIN_10 : COIN_5;
  endfunction

  disp_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

`ifdef COIN_DISP_TIMEOUT_EN
  logic [RETRY_W-1:0] retry, retry_n;
`endif

  always_comb begin
    state_n  = state;
    coin_n   = coin_out;
    rem_n    = remaining;
    tmr_load = 1'b0;
    tmr_val  = GAP_LOAD;
`ifdef COIN_DISP_TIMEOUT_EN
    retry_n  = retry;
`endif
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          rem_n = req_amount;
          if (req_amount == '0) begin
            state_n = S_DONE;
          end else begin
            state_n  = S_WAIT_ACK;
            coin_n   = pick_coin(req_amount);
            tmr_load = 1'b1;
            tmr_val  = ACK_LOAD;
`ifdef COIN_DISP_TIMEOUT_EN
            retry_n  = '0;
`endif
          end
        end
      end
      S_WAIT_ACK: begin
        // An ack coinciding with timer expiry takes priority over the timeout.
        if (coin_ack) begin
          rem_n    = remaining - ((coin_out == COIN_10) ? AMT_W'(UNITS_10) : AMT_W'(UNITS_5));
          coin_n   = COIN_NONE;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_n  = (rem_n == '0) ? S_DONE : S_GAP;
`ifdef COIN_DISP_TIMEOUT_EN
          retry_n  = '0;
        end else if (tmr_expire) begin
          coin_n  = COIN_NONE;
          retry_n = retry + 1'b1;
          if (retry_n == RETRY_W'(MAX_RETRY + 1)) begin
            state_n = S_ERR;
          end else begin
            state_n  = S_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end
`endif
        end
      end
      S_GAP: begin
        if (tmr_expire) begin
          state_n  = S_WAIT_ACK;
          coin_n   = pick_coin(remaining);
          tmr_load = 1'b1;
          tmr_val  = ACK_LOAD;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      S_ERR: begin
        coin_n = COIN_NONE;
        if (err_clr) begin
          state_n = S_IDLE;
          rem_n   = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        coin_n  = COIN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      coin_out  <= COIN_NONE;
      remaining <= '0;
    end else begin
      state     <= state_n;
      coin_out  <= coin_n;
      remaining <= rem_n;
    end
  end

`ifdef COIN_DISP_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry <= '0;
    end else begin
      retry <= retry_n;
    end
  end

  assign error = (state == S_ERR);
`else
  assign error = 1'b0;
`endif

  assign req_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: greedy coin model in currency units, random ack delays.
// Timeout scenarios run only when COIN_DISP_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_change_dispenser;

  localparam int unsigned AMT_W  = 4;
  localparam int unsigned GAP    = 4;
  localparam int unsigned ACK_TO = 1024;
  localparam int unsigned MAXR   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [AMT_W-1:0] req_amount = '0;
  logic             coin_ack = 1'b0;
  logic             err_clr = 1'b0;
  logic             req_ready, busy, done, error;
  logic [1:0]       coin_out;
  logic [AMT_W-1:0] remaining;

  int checks = 0;
  int errors = 0;

  change_dispenser #(
    .AMT_W       (AMT_W),
    .ACK_TIMEOUT (ACK_TO),
    .GAP_CYCLES  (GAP),
    .MAX_RETRY   (MAXR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_amount (req_amount),
    .req_ready  (req_ready),
    .coin_out   (coin_out),
    .coin_ack   (coin_ack),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input int amt);
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
    end
    req_valid  = 1'b1;
    req_amount = AMT_W'(amt);
    tick();
    req_valid  = 1'b0;
    req_amount = AMT_W'($urandom);
  endtask

  // Full refund against a greedy model: coin values in currency units, remaining = value left / 5.
  task automatic do_refund(input int amt, input int min_d, input int max_d, input bit intrude);
    int   coins[$];
    int   value;
    int   left;
    int   d;
    logic [1:0] exp_code;
    value = amt * 5;
    while (value >= 10) begin
      coins.push_back(10);
      value -= 10;
    end
    if (value == 5) coins.push_back(5);
    left = amt * 5;

    start_req(amt);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept amt=%0d: busy=%b required 1", amt, busy);
    end

    if (coins.size() == 0) begin
      checks++;
      if (done !== 1'b1 || coin_out !== 2'b00) begin
        errors++;
        $display("FAIL zero_done: done=%b coin_out=%b required 1 00", done, coin_out);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_after: done=%b busy=%b required 0 0", done, busy);
      end
      return;
    end

    foreach (coins[k]) begin
      exp_code = (coins[k] == 10) ? 2'b11 : 2'b10;
      d = $urandom_range(max_d, min_d);
      coin_ack = 1'b0;
      checks++;
      if (coin_out !== exp_code || remaining !== AMT_W'(left / 5)) begin
        errors++;
        $display("FAIL coin_issue amt=%0d k=%0d: coin_out=%b remaining=%0d required %b %0d",
                 amt, k, coin_out, remaining, exp_code, left / 5);
      end
      for (int i = 0; i < d; i++) begin
        if (intrude && k == 0 && i == 0) begin
          req_valid  = 1'b1;
          req_amount = AMT_W'(3);
          checks++;
          if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: req_ready=%b required 0", req_ready);
          end
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (coin_out !== exp_code) begin
          errors++;
          $display("FAIL coin_hold k=%0d: coin_out=%b required %b", k, coin_out, exp_code);
        end
      end
      coin_ack = 1'b1;
      tick();
      coin_ack = 1'b0;
      left -= coins[k];
      checks++;
      if (remaining !== AMT_W'(left / 5) || coin_out !== 2'b00) begin
        errors++;
        $display("FAIL after_ack k=%0d: remaining=%0d coin_out=%b required %0d 00",
                 k, remaining, coin_out, left / 5);
      end
      if (k == coins.size() - 1) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL done_pulse amt=%0d: done=%b required 1", amt, done);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || remaining !== '0 || coin_out !== 2'b00) begin
          errors++;
          $display("FAIL after_done amt=%0d: done=%b busy=%b remaining=%0d coin_out=%b required 0 0 0 00",
                   amt, done, busy, remaining, coin_out);
        end
      end else begin
        for (int g = 0; g < int'(GAP); g++) begin
          checks++;
          if (coin_out !== 2'b00 || done !== 1'b0 || remaining !== AMT_W'(left / 5)) begin
            errors++;
            $display("FAIL gap k=%0d g=%0d: coin_out=%b done=%b remaining=%0d required 00 0 %0d",
                     k, g, coin_out, done, remaining, left / 5);
          end
          coin_ack = 1'($urandom);
          tick();
        end
        coin_ack = 1'b0;
      end
    end
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL model_total amt=%0d: left=%0d required 0", amt, left);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (coin_out !== 2'b00 || remaining !== '0 || done !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: coin_out=%b remaining=%0d done=%b error=%b busy=%b required 00 0 0 0 0",
               coin_out, remaining, done, error, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_seven_with_intrusion();
    do_refund(7, 3, 3, 1'b1);
    tick();
    checks++;
    if (busy !== 1'b0 || coin_out !== 2'b00 || remaining !== '0) begin
      errors++;
      $display("FAIL intrusion_ignored: busy=%b coin_out=%b remaining=%0d required 0 00 0",
               busy, coin_out, remaining);
    end
  endtask

  task automatic test_zero();
    do_refund(0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      do_refund(int'($urandom_range(15, 0)), 0, 5, 1'b0);
    end
    do_refund(15, 0, 2, 1'b0);
    do_refund(1, 0, 2, 1'b0);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_idle: error=%b required 0", error);
    end
  endtask

  task automatic test_reset_mid();
    start_req(5);
    checks++;
    if (coin_out !== 2'b11) begin
      errors++;
      $display("FAIL mid_issue: coin_out=%b required 11", coin_out);
    end
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (coin_out !== 2'b00 || remaining !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: coin_out=%b remaining=%0d busy=%b required 00 0 0",
               coin_out, remaining, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || coin_out !== 2'b00) begin
      errors++;
      $display("FAIL after_reset: req_ready=%b coin_out=%b required 1 00", req_ready, coin_out);
    end
    do_refund(2, 0, 2, 1'b0);
  endtask

`ifdef COIN_DISP_TIMEOUT_EN
  task automatic test_timeout_err();
    int n;
    start_req(2);
    for (int a = 0; a <= int'(MAXR); a++) begin
      n = 0;
      while (coin_out === 2'b11 && n < 2000) begin
        n++;
        tick();
      end
      checks++;
      if (n != int'(ACK_TO)) begin
        errors++;
        $display("FAIL timeout_len a=%0d: cycles=%0d required %0d", a, n, ACK_TO);
      end
      if (a < int'(MAXR)) begin
        for (int g = 0; g < int'(GAP); g++) begin
          checks++;
          if (coin_out !== 2'b00 || error !== 1'b0) begin
            errors++;
            $display("FAIL retry_gap a=%0d g=%0d: coin_out=%b error=%b required 00 0", a, g, coin_out, error);
          end
          tick();
        end
      end
    end
    for (int h = 0; h < 3; h++) begin
      checks++;
      if (error !== 1'b1 || remaining !== AMT_W'(2) || coin_out !== 2'b00 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL err_state h=%0d: error=%b remaining=%0d coin_out=%b req_ready=%b required 1 2 00 0",
                 h, error, remaining, coin_out, req_ready);
      end
      tick();
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || error !== 1'b0 || remaining !== '0) begin
      errors++;
      $display("FAIL err_clear: req_ready=%b error=%b remaining=%0d required 1 0 0", req_ready, error, remaining);
    end
  endtask

  task automatic test_ack_at_expiry();
    start_req(2);
    for (int i = 0; i < int'(ACK_TO) - 1; i++) tick();
    checks++;
    if (coin_out !== 2'b11) begin
      errors++;
      $display("FAIL last_wait_cycle: coin_out=%b required 11", coin_out);
    end
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    checks++;
    if (remaining !== '0 || done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL ack_at_expiry: remaining=%0d done=%b error=%b required 0 1 0", remaining, done, error);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_seven_with_intrusion();
    test_zero();
    test_random();
    test_reset_mid();
`ifdef COIN_DISP_TIMEOUT_EN
    test_timeout_err();
    test_ack_at_expiry();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
